// File: rtl/change_encoder_pkg.sv
// Shared types and constants for the vending change encoder: FSM states,
// coin values in quarters and the change-display code mapping.
package change_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VEND,
    SHOW,
    REFUND
  } state_e;

  localparam logic [2:0] COIN_Q_VAL = 3'd1;
  localparam logic [2:0] COIN_H_VAL = 3'd2;
  localparam logic [2:0] COIN_D_VAL = 3'd4;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_25   = 4'd6;
  localparam logic [3:0] CODE_50   = 4'd7;
  localparam logic [3:0] CODE_75   = 4'd8;

  // Only 0..3 quarters can ever be owed; anything else shows nothing.
  function automatic logic [3:0] quarters_to_code(input logic [2:0] quarters);
    logic [3:0] code;
    unique case (quarters)
      3'd1:    code = CODE_25;
      3'd2:    code = CODE_50;
      3'd3:    code = CODE_75;
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/change_encoder_if.sv
// Coin-acceptor / display bus of the change encoder.
// CHANGE_TALLY_EN adds the tally_q dispensed-quarters counter to the bus.
interface change_encoder_if;

  logic       coin_q;
  logic       coin_h;
  logic       coin_d;
  logic       cancel;
  logic [3:0] change_code;
  logic       vend;
  logic       refund;
  logic       coin_reject;
  logic       busy;
  logic [2:0] credit_q;

`ifdef CHANGE_TALLY_EN
  logic [7:0] tally_q;

  modport master (
    output coin_q, coin_h, coin_d, cancel,
    input  change_code, vend, refund, coin_reject, busy, credit_q, tally_q
  );

  modport slave (
    input  coin_q, coin_h, coin_d, cancel,
    output change_code, vend, refund, coin_reject, busy, credit_q, tally_q
  );
`else
  modport master (
    output coin_q, coin_h, coin_d, cancel,
    input  change_code, vend, refund, coin_reject, busy, credit_q
  );

  modport slave (
    input  coin_q, coin_h, coin_d, cancel,
    output change_code, vend, refund, coin_reject, busy, credit_q
  );
`endif

endinterface

// File: rtl/change_encoder_hold_timer.sv
// Loadable down-counter: after load_i, done_o pulses on the HOLD_CYCLES-th
// following cycle, so a state that loads it on entry lasts HOLD_CYCLES cycles.
module hold_timer #(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // NOTE: every variable written in a combinational block gets a default
  // first, otherwise an unassigned path infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/change_encoder.sv
// Vending transaction controller: accumulates coin credit, vends, and shows
// the change/refund code. Define CHANGE_TALLY_EN for the dispensed tally.
module change_encoder
  import change_pkg::*;
#(
  parameter int unsigned PRICE_Q     = 3,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  change_encoder_if.slave   bus
);

  localparam logic [2:0] PRICE = 3'(PRICE_Q);

  state_e     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [3:0] code_q, code_d;
  logic       reject_q, reject_d;

  logic [1:0] coin_cnt;
  logic [2:0] coin_val;
  logic       at_price;
  logic       coin_ok;
  logic       hold_load;
  logic       hold_done;
  logic [2:0] dispensed;

  assign coin_cnt = 2'(bus.coin_q) + 2'(bus.coin_h) + 2'(bus.coin_d);
  assign coin_val = ({3{bus.coin_q}} & COIN_Q_VAL)
                  | ({3{bus.coin_h}} & COIN_H_VAL)
                  | ({3{bus.coin_d}} & COIN_D_VAL);
  assign at_price = (credit_q >= PRICE);

  // Once the price is reached the next edge vends, so further coins bounce;
  // this keeps credit within PRICE_Q+3 and refunds within 3 quarters.
  assign coin_ok = (coin_cnt == 2'd1) && !bus.cancel &&
                   ((state_q == IDLE) || ((state_q == COLLECT) && !at_price));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (coin_ok) state_d = COLLECT;
      COLLECT: begin
        if (at_price)                             state_d = VEND;
        else if (bus.cancel && credit_q != 3'd0)  state_d = REFUND;
      end
      VEND:         state_d = SHOW;
      SHOW, REFUND: if (hold_done) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.vend        = (state_q == VEND);
    bus.refund      = (state_q == REFUND);
    bus.busy        = (state_q == VEND) || (state_q == SHOW) || (state_q == REFUND);
    bus.change_code = code_q;
    bus.coin_reject = reject_q;
    bus.credit_q    = credit_q;
  end

  assign hold_load = (state_q == VEND) || ((state_q == COLLECT) && (state_d == REFUND));
  assign dispensed = (state_q == VEND) ? (credit_q - PRICE) : credit_q;

  always_comb begin
    credit_d = credit_q;
    code_d   = code_q;
    reject_d = (coin_cnt != 2'd0) && !coin_ok;
    if (coin_ok) credit_d = credit_q + coin_val;
    if (hold_load) begin
      code_d   = quarters_to_code(dispensed);
      credit_d = 3'd0;
    end else if (hold_done && ((state_q == SHOW) || (state_q == REFUND))) begin
      code_d = CODE_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= 3'd0;
      code_q   <= CODE_NONE;
      reject_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      code_q   <= code_d;
      reject_q <= reject_d;
    end
  end

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (hold_load),
    .done_o (hold_done)
  );

`ifdef CHANGE_TALLY_EN
  logic [7:0] tally_q, tally_d;
  logic [8:0] tally_sum;

  assign tally_sum = {1'b0, tally_q} + 9'(dispensed);

  always_comb begin
    tally_d = tally_q;
    if (hold_load) tally_d = tally_sum[8] ? 8'hFF : tally_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tally_q <= 8'd0;
    else        tally_q <= tally_d;
  end

  assign bus.tally_q = tally_q;
`endif

endmodule
